// File: rtl/hazard_stall_ctrl_if.sv
// Bundles the hazard controller's pipeline, dmem and status signals.
// The slave modport is the controller side and the master modport is the pipeline side.
interface hazard_stall_ctrl_if;
  logic [4:0]  IFID_RegRs;
  logic [4:0]  IFID_RegRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_RegRt;
  logic        EXMEM_MemRead;
  logic        EXMEM_MemWrite;
  logic        dmem_ready;
  logic        branch_taken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXWrite;
  logic        EXMEMWrite;
  logic        MEMWBWrite;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        dmem_req;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport slave (
    input  IFID_RegRs, IFID_RegRt, IDEX_MemRead, IDEX_RegRt,
           EXMEM_MemRead, EXMEM_MemWrite, dmem_ready, branch_taken,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
           IFID_flush, IDEX_flush, dmem_req, mem_timeout, stall_cycles
  );

  modport master (
    output IFID_RegRs, IFID_RegRt, IDEX_MemRead, IDEX_RegRt,
           EXMEM_MemRead, EXMEM_MemWrite, dmem_ready, branch_taken,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
           IFID_flush, IDEX_flush, dmem_req, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: dmem wait-state stalls with timeout, taken-branch flushes
// and load-use interlock. Stall cycles are counted, and the count saturates.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              rst,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

  localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  waitCnt_q;
  logic        memTimeout_q;
  logic [31:0] stallCycles_q;

  logic memAcc;
  logic memStall;
  logic loadUse;

  assign memAcc   = hz.EXMEM_MemRead | hz.EXMEM_MemWrite;
  assign memStall = ((state_q == RUN) & memAcc & ~hz.dmem_ready) |
                    ((state_q == MEM_WAIT) & ~hz.dmem_ready);
  assign loadUse  = hz.IDEX_MemRead & (hz.IDEX_RegRt != 5'd0) &
                    ((hz.IDEX_RegRt == hz.IFID_RegRs) | (hz.IDEX_RegRt == hz.IFID_RegRt));

  // Priority: reset > error > memory stall > branch > load-use > normal.
  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    hz.IDEXWrite  = 1'b1;
    hz.EXMEMWrite = 1'b1;
    hz.MEMWBWrite = 1'b1;
    hz.IFID_flush = 1'b0;
    hz.IDEX_flush = 1'b0;
    hz.dmem_req   = memAcc;
    if (rst || state_q == ERR) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IDEXWrite  = 1'b0;
      hz.EXMEMWrite = 1'b0;
      hz.MEMWBWrite = 1'b0;
      hz.dmem_req   = 1'b0;
    end else if (memStall) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IDEXWrite  = 1'b0;
      hz.EXMEMWrite = 1'b0;
      hz.MEMWBWrite = 1'b0;
    end else if (hz.branch_taken) begin
      hz.IFID_flush = 1'b1;
      hz.IDEX_flush = 1'b1;
    end else if (loadUse) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IDEX_flush = 1'b1;
    end
  end

  assign hz.mem_timeout  = memTimeout_q;
  assign hz.stall_cycles = stallCycles_q;

  // The wait counter reaching its limit while dmem is still busy locks the FSM in ERR until reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= RUN;
      waitCnt_q     <= 8'd0;
      memTimeout_q  <= 1'b0;
      stallCycles_q <= 32'd0;
    end else begin
      if (!hz.PCWrite && stallCycles_q != 32'hFFFF_FFFF)
        stallCycles_q <= stallCycles_q + 32'd1;
      unique case (state_q)
        RUN: begin
          if (memStall) begin
            state_q   <= MEM_WAIT;
            waitCnt_q <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready) begin
            state_q   <= RUN;
            waitCnt_q <= 8'd0;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
            if (waitCnt_q == WaitLimit) begin
              state_q      <= ERR;
              memTimeout_q <= 1'b1;
            end
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

endmodule
